// File: rtl/ras_pkg.sv
// Shared types and decode constants for the return-address-stack controller.
// Optional compressed decode is enabled with RAS_CTRL_RVC_EN.
package ras_pkg;

    typedef struct packed {
        logic push;
        logic pop;
    } ras_act_t;

    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [2:0] F3_JALR     = 3'b000;

    localparam logic [1:0] RVC_OP_C1   = 2'b01;
    localparam logic [1:0] RVC_OP_C2   = 2'b10;
    localparam logic [2:0] RVC_F3_JAL  = 3'b001;
    localparam logic [3:0] RVC_F4_JR   = 4'b1000;
    localparam logic [3:0] RVC_F4_JALR = 4'b1001;

    localparam logic [4:0] LINK_X1     = 5'd1;
    localparam logic [4:0] LINK_X5     = 5'd5;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        FLUSH_A = 2'd1,
        FLUSH_C = 2'd2
    } ras_state_e;

    function automatic logic is_link(input logic [4:0] r);
        return (r == LINK_X1) || (r == LINK_X5);
    endfunction

endpackage

// File: rtl/ras_fifo.sv
// In-order queue of in-flight stack actions; head is read out registered
// on the cycle after a pop, which lines up with the commit replay.
module ras_fifo
    import ras_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] dout_q;

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem[wr_ptr_q] <= din_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            dout_q   <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                dout_q   <= mem[rd_ptr_q];
            end
        end
    end

    assign dout_o = dout_q;

endmodule

// File: rtl/ras_ctrl.sv
// Call/return classifier and commit sequencer in front of the return address
// stack. Define RAS_CTRL_RVC_EN to also decode compressed jumps.
module ras_ctrl
    import ras_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int MAX_INFLIGHT = 16
) (
    input  logic             clk,
    input  logic             rst_ni,
    input  logic             fetch_valid,
    output logic             fetch_ready,
    input  logic [WIDTH-1:0] fetch_pc,
    input  logic [31:0]      fetch_instr,
    input  logic             ret_valid,
    input  logic             flush_in,
    output logic             ras_push,
    output logic             ras_pop,
    output logic [WIDTH-1:0] ras_din,
    output logic             ras_commit_push,
    output logic             ras_commit_pop,
    output logic             ras_flush,
    input  logic [WIDTH-1:0] ras_dout,
    input  logic             ras_empty,
    output logic             pred_valid,
    output logic [WIDTH-1:0] pred_target,
    output logic             err
);

    localparam int CNT_W = $clog2(MAX_INFLIGHT) + 1;

    ras_state_e       state_q, state_d;
    ras_act_t         act_q, act_d, dec_act, head;
    logic             act_vld_q, act_vld_d;
    logic [WIDTH-1:0] din_q, din_d, dec_link;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cmt_vld_q, cmt_vld_d;
    logic             err_q, err_d;
    logic             fsm_run, flush_clr, full, fetch_accept, deq;
    logic [4:0]       rd, rs1;
    logic             unused_instr;

    assign rd           = fetch_instr[11:7];
    assign rs1          = fetch_instr[19:15];
    assign unused_instr = ^fetch_instr[31:20];

    always_comb begin
        dec_act  = '0;
        dec_link = fetch_pc + WIDTH'(4);
        if (fetch_instr[1:0] == 2'b11) begin
            if (fetch_instr[6:0] == OPC_JAL) begin
                dec_act.push = is_link(rd);
            end else if (fetch_instr[6:0] == OPC_JALR && fetch_instr[14:12] == F3_JALR) begin
                // rd==rs1 with both link registers is a plain call, not a coroutine swap.
                dec_act.push = is_link(rd);
                dec_act.pop  = is_link(rs1) && !(is_link(rd) && rd == rs1);
            end
        end
`ifdef RAS_CTRL_RVC_EN
        else begin
            dec_link = fetch_pc + WIDTH'(2);
            if (fetch_instr[1:0] == RVC_OP_C1 && fetch_instr[15:13] == RVC_F3_JAL) begin
                dec_act.push = 1'b1;
            end else if (fetch_instr[1:0] == RVC_OP_C2 && fetch_instr[6:2] == 5'd0 && rd != 5'd0) begin
                if (fetch_instr[15:12] == RVC_F4_JR) begin
                    dec_act.pop = is_link(rd);
                end else if (fetch_instr[15:12] == RVC_F4_JALR) begin
                    dec_act.push = 1'b1;
                    dec_act.pop  = (rd == LINK_X5);
                end
            end
        end
`endif
    end

    // The registered action not yet enqueued still occupies a slot.
    assign full         = (cnt_q + CNT_W'(act_vld_q)) >= CNT_W'(MAX_INFLIGHT);
    assign fetch_ready  = rst_ni && fsm_run && !full;
    assign fetch_accept = fetch_valid && fetch_ready && !flush_in && (dec_act.push || dec_act.pop);
    assign deq          = ret_valid && fsm_run && (cnt_q != '0);

    always_comb begin
        act_vld_d = fetch_accept;
        act_d     = fetch_accept ? dec_act : act_q;
        din_d     = fetch_accept ? dec_link : din_q;
        cmt_vld_d = deq;
        err_d     = err_q || (ret_valid && fsm_run && (cnt_q == '0));
        if (flush_clr) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(act_vld_q) - CNT_W'(deq);
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= RUN;
            act_vld_q <= 1'b0;
            act_q     <= '0;
            din_q     <= '0;
            cnt_q     <= '0;
            cmt_vld_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            act_vld_q <= act_vld_d;
            act_q     <= act_d;
            din_q     <= din_d;
            cnt_q     <= cnt_d;
            cmt_vld_q <= cmt_vld_d;
            err_q     <= err_d;
        end
    end

    // A retire coinciding with the flush detours through FLUSH_C so the commit lands first.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (flush_in) state_d = ret_valid ? FLUSH_C : FLUSH_A;
            FLUSH_C: state_d = FLUSH_A;
            FLUSH_A: state_d = flush_in ? FLUSH_A : RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        fsm_run   = (state_q == RUN);
        ras_flush = (state_q == FLUSH_A);
        flush_clr = (state_q == FLUSH_A);
    end

    ras_fifo #(
        .WIDTH (2),
        .DEPTH (MAX_INFLIGHT)
    ) u_fifo (
        .clk    (clk),
        .rst_ni (rst_ni),
        .clr_i  (flush_clr),
        .push_i (act_vld_q),
        .din_i  (act_q),
        .pop_i  (deq),
        .dout_o (head)
    );

    assign ras_push        = act_vld_q && act_q.push;
    assign ras_pop         = act_vld_q && act_q.pop;
    assign ras_din         = ras_push ? din_q : '0;
    assign pred_valid      = ras_pop && !ras_empty;
    assign pred_target     = ras_pop ? ras_dout : '0;
    assign ras_commit_push = cmt_vld_q && head.push;
    assign ras_commit_pop  = cmt_vld_q && head.pop;
    assign err             = err_q;

endmodule

// File: doc/ras_ctrl.md
# ras_ctrl

Call/return classifier and commit sequencer directly upstream of the return address stack. Decodes each fetched instruction under the RISC-V link-register hints to produce speculative push/pop and the link address for the stack. Records every stack action in an in-order in-flight queue and replays it as commit_push/commit_pop when the backend retires the instruction. Turns backend mispredict flushes into a correctly ordered stack flush, and returns the stack top as the return-target prediction.

## Interface
- WIDTH, 32, address width; equals the stack's data width
- MAX_INFLIGHT, 16, in-flight call/return queue depth; power of two, ≥2
- clk  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- fetch_valid  in  1  fetch_pc and fetch_instr valid
- fetch_ready  out  1  block accepts the fetch this cycle
- fetch_pc  in  WIDTH  instruction address
- fetch_instr  in  32  instruction bits
- ret_valid  in  1  oldest tracked call/return retired, one per cycle, in order
- flush_in  in  1  backend mispredict; discard all speculative state
- ras_push, ras_pop  out  1  speculative stack action
- ras_din  out  WIDTH  link address pushed
- ras_commit_push, ras_commit_pop  out  1  retire replay to the stack
- ras_flush  out  1  restore stack to committed pointer
- ras_dout  in  WIDTH  current stack top
- ras_empty  in  1  stack empty
- pred_valid  out  1  pred_target holds a usable return target
- pred_target  out  WIDTH  predicted return address
- err  out  1  sticky: retire with empty queue; cleared only by reset

## Operation
- Link register: x1 or x5. JAL with link rd: push. JALR, rd link and rs1 not link: push. JALR, rd not link and rs1 link: pop. JALR, both link and rd≠rs1: pop and push in the same cycle. JALR, both link and rd==rs1: push only. Any other instruction: no action and no queue entry.
- Link address = fetch_pc + 4, truncated to WIDTH bits, so it wraps.
- An accepted fetch (fetch_valid && fetch_ready) with an action is registered. In the next cycle the block drives ras_push/ras_pop and ras_din, and enqueues the 2-bit action {push,pop}.
- On a pop cycle: pred_valid = !ras_empty and pred_target = ras_dout. pred_valid is 0 in every other cycle.
- The pop is issued even when the stack is empty; the stack handles underflow.
- fetch_ready = !full, where full counts the registered action not yet enqueued. fetch_ready is also low in the flush states.
- On ret_valid: dequeue the head, then drive ras_commit_push/ras_commit_pop with the head's bits in the next cycle. Both may be high together.
- ret_valid with an empty queue: ignored, and err is set.
- FSM states:
  - RUN
  - FLUSH_A (flush_in without ret_valid): ras_flush=1 for one cycle, queue cleared, registered action dropped, then RUN.
  - FLUSH_C (flush_in with ret_valid): commit emitted this cycle, then FLUSH_A. The commit always precedes the flush.
- flush_in while in a flush state: stay in FLUSH_A for one more cycle.
- A fetch in the same cycle as flush_in is dropped.
- Reset values: all outputs 0 except fetch_ready=0 while reset is asserted and 1 from the first cycle after deassertion; queue empty; state RUN.

## Timing
- Fetch to ras_push/ras_pop/ras_din: 1 cycle. pred_* is valid in that same cycle.
- ret_valid to ras_commit_*: 1 cycle.
- flush_in to ras_flush: 1 cycle, or 2 cycles when it coincides with ret_valid.
- Queue enqueue and dequeue in the same cycle: occupancy unchanged. Pointers wrap mod MAX_INFLIGHT.
- Back-to-back push then pop: supported; the stack forwards the pushed value.

## Configuration
- RAS_CTRL_RVC_EN defined: instructions with fetch_instr[1:0]!=2'b11 are decoded as compressed, with link = pc+2.
  - C.JAL: push.
  - C.JR with rs1 link: pop.
  - C.JALR (rd=x1): push if rs1==x1, pop+push if rs1==x5, push otherwise.
- RAS_CTRL_RVC_EN undefined: compressed encodings take no action, and every link address is pc+4.

## Structure
- ras_pkg holds: the action struct {push,pop}, the OPC_JAL/OPC_JALR/RVC funct constants, the LINK_X1/LINK_X5 constants, and the FSM state enum.
- Sub-module: ras_fifo (WIDTH=2, DEPTH=MAX_INFLIGHT) as the in-flight queue, reset by reset or flush. The occupancy counter is kept in ras_ctrl.

## Test plan
- JAL x1 at pc 0x100 → next cycle ras_push=1, ras_din=0x104, one queue entry.
- JALR x0,x1 with ras_dout=0x104, ras_empty=0 → ras_pop=1, pred_valid=1, pred_target=0x104.
- JALR x5,x1 → ras_pop=ras_push=1; a later ret_valid → ras_commit_pop=ras_commit_push=1.
- Sixteen calls with no retire → fetch_ready=0; one ret_valid → fetch_ready=1 one cycle later.
- flush_in with ret_valid on a 3-entry queue → commit at +1, ras_flush at +2, queue empty, fetch_ready low through +2.
- ret_valid after reset with an empty queue → no commit; err=1 and it stays set.
